dac_scan_sequencer: RTL and testbench

- Autonomous threshold-scan engine sitting directly upstream of the DAC serializer (DAC_CTRL_v3).
- Drives the serializer's write port (we/waddr/dat) and its update strobe.
- Steps a common DAC value across a masked set of the 32 channels from start to stop in fixed increments.
- Holds each point for a programmable dwell window, during which downstream scalers count.

---
 rtl/dac_scan_sequencer_if.sv | 30 +++
 rtl/dac_scan_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_dac_scan_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/dac_scan_sequencer_if.sv
// Bus bundle between the scan host and the threshold-scan sequencer.
// The host (master) drives the scan request and parameters; the sequencer (slave)
// drives the DAC serializer write port, update strobe and scan status.
interface dac_scan_sequencer_if;
  logic        start_i;
  logic        stop_i;
  logic [15:0] start_val_i;
  logic [15:0] stop_val_i;
  logic [15:0] step_i;
  logic [15:0] dwell_i;
  logic [31:0] chan_mask_i;
  logic        dac_we_o;
  logic [4:0]  dac_waddr_o;
  logic [15:0] dac_dat_o;
  logic        update_o;
  logic        gate_o;
  logic [15:0] cur_val_o;
  logic        busy_o;
  logic        done_o;

  modport master (
    output start_i, stop_i, start_val_i, stop_val_i, step_i, dwell_i, chan_mask_i,
    input  dac_we_o, dac_waddr_o, dac_dat_o, update_o, gate_o, cur_val_o, busy_o, done_o
  );

  modport slave (
    input  start_i, stop_i, start_val_i, stop_val_i, step_i, dwell_i, chan_mask_i,
    output dac_we_o, dac_waddr_o, dac_dat_o, update_o, gate_o, cur_val_o, busy_o, done_o
  );
endinterface

// File: rtl/dac_scan_sequencer.sv
// Threshold-scan engine feeding the DAC serializer write port.
// Steps a common DAC value from start to stop across the masked channels,
// holding each point for a settle time and then a dwell (gate) window.
// Build option: define DAC_SCAN_RESTORE_EN to rewrite the masked channels back to
// the start value (one extra LOAD + UPD) before the scan reports done.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start
// LOAD   | 32 cycles writing cur value to serializer RAM, addr 0..31
// UPD    | one-cycle serializer update strobe
// SETTLE | SETTLE_CYCLES wait for frame + analog settling
// DWELL  | gate window, max(dwell,1) cycles
// NEXT   | compute next point or finish
// FIN    | one-cycle done pulse
module dac_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 256,  // must be >= 1
  parameter int unsigned NCHAN         = 32
) (
  input logic           clk_i,
  input logic           rst_n_i,
  dac_scan_sequencer_if.slave bus
);

  localparam logic [4:0]  LAST_ADDR   = 5'(NCHAN - 1);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_UPD, S_SETTLE, S_DWELL, S_NEXT, S_FIN
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  addr, addr_nxt;
  logic [15:0] timer, timer_nxt;
  logic [15:0] cur, cur_nxt;
  logic [15:0] stop_lat, stop_lat_nxt;
  logic [15:0] step_lat, step_lat_nxt;
  logic [15:0] dwell_lat, dwell_lat_nxt;
  logic [31:0] mask_lat, mask_lat_nxt;
  logic        stop_pend, stop_pend_nxt;
  logic        restore_ph, restore_ph_nxt;
`ifdef DAC_SCAN_RESTORE_EN
  logic [15:0] start_lat, start_lat_nxt;
`endif

  logic [16:0] sum;
  logic [15:0] dwell_load;
  logic        end_req;

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      addr       <= '0;
      timer      <= '0;
      cur        <= '0;
      stop_lat   <= '0;
      step_lat   <= '0;
      dwell_lat  <= '0;
      mask_lat   <= '0;
      stop_pend  <= 1'b0;
      restore_ph <= 1'b0;
`ifdef DAC_SCAN_RESTORE_EN
      start_lat  <= '0;
`endif
    end else begin
      state      <= state_nxt;
      addr       <= addr_nxt;
      timer      <= timer_nxt;
      cur        <= cur_nxt;
      stop_lat   <= stop_lat_nxt;
      step_lat   <= step_lat_nxt;
      dwell_lat  <= dwell_lat_nxt;
      mask_lat   <= mask_lat_nxt;
      stop_pend  <= stop_pend_nxt;
      restore_ph <= restore_ph_nxt;
`ifdef DAC_SCAN_RESTORE_EN
      start_lat  <= start_lat_nxt;
`endif
    end
  end

  // Next-state, datapath update and output decode
  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr;
    timer_nxt      = timer;
    cur_nxt        = cur;
    stop_lat_nxt   = stop_lat;
    step_lat_nxt   = step_lat;
    dwell_lat_nxt  = dwell_lat;
    mask_lat_nxt   = mask_lat;
    stop_pend_nxt  = stop_pend;
    restore_ph_nxt = restore_ph;
`ifdef DAC_SCAN_RESTORE_EN
    start_lat_nxt  = start_lat;
`endif
    end_req         = 1'b0;
    sum             = {1'b0, cur} + {1'b0, step_lat};
    dwell_load      = (dwell_lat == 16'd0) ? 16'd0 : dwell_lat - 16'd1;

    bus.dac_we_o    = 1'b0;
    bus.dac_waddr_o = '0;
    bus.dac_dat_o   = '0;
    bus.update_o    = 1'b0;
    bus.gate_o      = 1'b0;
    bus.done_o      = 1'b0;
    bus.busy_o      = (state != S_IDLE);
    bus.cur_val_o   = cur;

    case (state)
      S_IDLE: begin
        if (bus.start_i) begin
          state_nxt      = S_LOAD;
          cur_nxt        = bus.start_val_i;
          stop_lat_nxt   = bus.stop_val_i;
          step_lat_nxt   = bus.step_i;
          dwell_lat_nxt  = bus.dwell_i;
          mask_lat_nxt   = bus.chan_mask_i;
          addr_nxt       = '0;
          stop_pend_nxt  = 1'b0;
          restore_ph_nxt = 1'b0;
`ifdef DAC_SCAN_RESTORE_EN
          start_lat_nxt  = bus.start_val_i;
`endif
        end
      end
      S_LOAD: begin
        bus.dac_we_o    = mask_lat[addr];
        bus.dac_waddr_o = addr;
        bus.dac_dat_o   = cur;
        // An abort here is deferred so RAM and DAC output stay consistent
        if (bus.stop_i && !restore_ph) stop_pend_nxt = 1'b1;
        if (addr == LAST_ADDR) begin
          state_nxt = S_UPD;
          addr_nxt  = '0;
        end else begin
          addr_nxt = addr + 5'd1;
        end
      end
      S_UPD: begin
        bus.update_o = 1'b1;
        if (restore_ph) begin
          state_nxt = S_FIN;
        end else if (stop_pend || bus.stop_i) begin
          end_req = 1'b1;
        end else begin
          state_nxt = S_SETTLE;
          timer_nxt = SETTLE_LOAD;
        end
      end
      S_SETTLE: begin
        if (bus.stop_i) begin
          end_req = 1'b1;
        end else if (timer == 16'd0) begin
          state_nxt = S_DWELL;
          timer_nxt = dwell_load;
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end
      S_DWELL: begin
        bus.gate_o = 1'b1;
        if (bus.stop_i) begin
          end_req = 1'b1;
        end else if (timer == 16'd0) begin
          state_nxt = S_NEXT;
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end
      S_NEXT: begin
        // sum[16] catches wrap past 0xFFFF so the scan never restarts low
        if (bus.stop_i || (step_lat == 16'd0) || sum[16] || (sum[15:0] > stop_lat)) begin
          end_req = 1'b1;
        end else begin
          cur_nxt   = sum[15:0];
          addr_nxt  = '0;
          state_nxt = S_LOAD;
        end
      end
      S_FIN: begin
        bus.done_o     = 1'b1;
        state_nxt      = S_IDLE;
        stop_pend_nxt  = 1'b0;
        restore_ph_nxt = 1'b0;
        timer_nxt      = '0;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (end_req) begin
`ifdef DAC_SCAN_RESTORE_EN
      state_nxt      = S_LOAD;
      cur_nxt        = start_lat;
      addr_nxt       = '0;
      restore_ph_nxt = 1'b1;
      stop_pend_nxt  = 1'b0;
`else
      state_nxt = S_FIN;
`endif
    end
  end

endmodule

// File: tb/tb_dac_scan_sequencer.sv
// Self-checking bench for dac_scan_sequencer: directed and random scans compared
// against a point-list / cycle-count model of the scan.
module tb_dac_scan_sequencer;
  localparam int SETTLE = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dac_scan_sequencer_if bus();

  dac_scan_sequencer dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {22'd0, bus.dac_we_o, bus.dac_waddr_o, bus.dac_dat_o, bus.update_o,
            bus.gate_o, bus.cur_val_o, bus.busy_o, bus.done_o};
  endfunction

  task automatic scramble();
    bus.start_val_i = 16'($urandom);
    bus.stop_val_i  = 16'($urandom);
    bus.step_i      = 16'($urandom);
    bus.dwell_i     = 16'($urandom);
    bus.chan_mask_i = $urandom;
  endtask

  task automatic run_scan(input logic [15:0] sv, input logic [15:0] pv, input logic [15:0] st,
                          input logic [15:0] dw, input logic [31:0] mk,
                          input int stop_at, input int poke_at);
    int d, p_len, npts, nexec, fin, gates, pnt, off, g, idx, gate_cnt, done_idx, v, n;
    int pts[$];
    logic [20:0] e_wr[$];
    logic [20:0] a_wr[$];
    int e_upos[$];
    int a_upos[$];
    logic [15:0] e_uval[$];
    logic [15:0] a_uval[$];
    logic [15:0] final_v;
    logic [5:0] first;
    bit done_seen;

    // Reference: list of points, then timeline from cycles-per-point arithmetic
    d = (dw == 16'd0) ? 1 : int'(dw);
    p_len = 32 + 1 + SETTLE + d + 1;
    v = int'(sv);
    forever begin
      pts.push_back(v);
      if (st == 16'd0 || v + int'(st) > 65535 || v + int'(st) > int'(pv)) break;
      v = v + int'(st);
    end
    npts = pts.size();
    nexec = npts;
    fin = npts * p_len;
    gates = npts * d;
    if (stop_at >= 0 && stop_at < npts * p_len) begin
      pnt = stop_at / p_len;
      off = stop_at % p_len;
      nexec = pnt + 1;
      if (off < 33) begin
        fin = pnt * p_len + 33;
        gates = pnt * d;
      end else begin
        fin = stop_at + 1;
        g = off - (33 + SETTLE) + 1;
        if (g < 0) g = 0;
        if (g > d) g = d;
        gates = pnt * d + g;
      end
    end
    for (int k = 0; k < nexec; k++) begin
      for (int a = 0; a < 32; a++)
        if (mk[a]) e_wr.push_back({5'(a), 16'(pts[k])});
      e_upos.push_back(e_wr.size());
      e_uval.push_back(16'(pts[k]));
    end
    final_v = 16'(pts[nexec-1]);
`ifdef DAC_SCAN_RESTORE_EN
    fin = fin + 33;
    for (int a = 0; a < 32; a++)
      if (mk[a]) e_wr.push_back({5'(a), sv});
    e_upos.push_back(e_wr.size());
    e_uval.push_back(sv);
    final_v = sv;
`endif

    @(posedge clk); #1;
    bus.start_val_i = sv;
    bus.stop_val_i  = pv;
    bus.step_i      = st;
    bus.dwell_i     = dw;
    bus.chan_mask_i = mk;
    bus.start_i     = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;

    idx = 0;
    done_seen = 0;
    gate_cnt = 0;
    done_idx = -1;
    first = '0;
    while (!done_seen && idx < fin + 200) begin
      bus.stop_i  = (idx == stop_at);
      bus.start_i = (idx == poke_at);
      if (idx == 0 || idx == poke_at) scramble();
      @(negedge clk);
      if (idx == 0) first = {bus.busy_o, bus.dac_waddr_o};
      if (bus.dac_we_o) a_wr.push_back({bus.dac_waddr_o, bus.dac_dat_o});
      if (bus.update_o) begin
        a_upos.push_back(a_wr.size());
        a_uval.push_back(bus.cur_val_o);
      end
      if (bus.gate_o) gate_cnt++;
      if (bus.done_o) begin
        done_seen = 1;
        done_idx = idx;
      end
      @(posedge clk); #1;
      idx++;
    end
    bus.stop_i  = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clk);

    check("done_seen", 64'(done_seen), 64'd1);
    check("done_cycle", 64'(done_idx), 64'(fin));
    check("idle_after_done", 64'({bus.busy_o, bus.done_o}), 64'd0);
    check("first_load_cycle", 64'(first), 64'({1'b1, 5'd0}));
    check("n_writes", 64'(a_wr.size()), 64'(e_wr.size()));
    n = (a_wr.size() < e_wr.size()) ? a_wr.size() : e_wr.size();
    for (int i = 0; i < n; i++) check("write_addr_dat", 64'(a_wr[i]), 64'(e_wr[i]));
    check("n_updates", 64'(a_upos.size()), 64'(e_upos.size()));
    n = (a_upos.size() < e_upos.size()) ? a_upos.size() : e_upos.size();
    for (int i = 0; i < n; i++) begin
      check("update_after_writes", 64'(a_upos[i]), 64'(e_upos[i]));
      check("update_value", 64'(a_uval[i]), 64'(e_uval[i]));
    end
    check("gate_cycles", 64'(gate_cnt), 64'(gates));
    check("final_cur_val", 64'(bus.cur_val_o), 64'(final_v));
  endtask

  initial begin
    int n, npt, tmp, p_est, stp, pk;
    logic [15:0] sv, pv, st, dw;
    logic [31:0] mk;

    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
    bus.start_val_i = '0;
    bus.stop_val_i  = '0;
    bus.step_i      = '0;
    bus.dwell_i     = '0;
    bus.chan_mask_i = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs(), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Three points 100/150/200, full mask, dwell 10
    run_scan(16'd100, 16'd200, 16'd50, 16'd10, 32'hFFFF_FFFF, -1, -1);
    // Single point, channels 0 and 2 only
    run_scan(16'h0ABC, 16'h0ABC, 16'd1, 16'd3, 32'h0000_0005, -1, -1);
    // Overflow terminates with no wrap; dwell 0 acts as 1
    run_scan(16'hFFF0, 16'hFFFF, 16'h0020, 16'd0, 32'h8000_0001, -1, -1);
    // Abort in LOAD cycle 10 of the second point
    run_scan(16'd100, 16'd200, 16'd50, 16'd10, 32'hFFFF_FFFF, 300 + 10, -1);
    // Abort in the middle of the first dwell
    run_scan(16'd100, 16'd200, 16'd50, 16'd10, 32'h00F0_0F0F, 33 + SETTLE + 4, -1);
    // Start pulses while busy are ignored (in LOAD and in DWELL)
    run_scan(16'd100, 16'd200, 16'd50, 16'd10, 32'h1234_5678, -1, 12);
    run_scan(16'd100, 16'd200, 16'd50, 16'd10, 32'h1234_5678, -1, 33 + SETTLE + 2);
    // start > stop, step 0, and empty mask
    run_scan(16'd500, 16'd100, 16'd7, 16'd2, 32'hFFFF_0000, -1, -1);
    run_scan(16'd40, 16'd900, 16'd0, 16'd5, 32'h0000_FFFF, -1, -1);
    run_scan(16'd10, 16'd30, 16'd10, 16'd1, 32'h0000_0000, -1, -1);

    // Reset during DWELL, then a fresh scan
    @(posedge clk); #1;
    bus.start_val_i = 16'd100;
    bus.stop_val_i  = 16'd200;
    bus.step_i      = 16'd50;
    bus.dwell_i     = 16'd10;
    bus.chan_mask_i = 32'hFFFF_FFFF;
    bus.start_i     = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    n = 0;
    while (!bus.gate_o && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_dwell", 64'(bus.gate_o), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_in_dwell", outs(), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_scan(16'd300, 16'd340, 16'd20, 16'd4, 32'hA5A5_5A5A, -1, -1);

    // Random scans with optional abort and busy start pokes
    for (int r = 0; r < 6; r++) begin
      sv  = 16'($urandom);
      st  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 3000));
      npt = int'($urandom_range(1, 4));
      tmp = int'(sv) + int'(st) * (npt - 1) + ((st > 16'd0) ? int'($urandom_range(0, int'(st) - 1)) : 0);
      pv  = (tmp > 65535) ? 16'hFFFF : 16'(tmp);
      dw  = 16'($urandom_range(0, 40));
      mk  = $urandom;
      p_est = 34 + SETTLE + ((dw == 16'd0) ? 1 : int'(dw));
      stp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, npt * p_est)) : -1;
      pk  = int'($urandom_range(1, 250));
      run_scan(sv, pv, st, dw, mk, stp, pk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
